// File: rtl/vram_write_queue.sv
// Byte-write queue between the video command receiver and the external video SRAM.
// Entries are buffered in a small FIFO and committed with a setup/strobe/hold write cycle.
module vram_write_queue #(
    parameter int AWIDTH    = 18,
    parameter int DWIDTH    = 8,
    parameter int DEPTHLOG2 = 4
) (
    input  logic                 ClkIn,
    input  logic                 ResetIn,
    input  logic                 WrStrobeIn,
    input  logic [AWIDTH-1:0]    WrAddrIn,
    input  logic [DWIDTH-1:0]    WrDataIn,
    input  logic                 BusGrantIn,
    input  logic                 OverflowClrIn,
    output logic [AWIDTH-1:0]    SramAddrOut,
    output logic [DWIDTH-1:0]    SramDataOut,
    output logic                 SramDataOeOut,
    output logic                 SramWeOut,
    output logic                 BusyOut,
    output logic                 EmptyOut,
    output logic                 FullOut,
    output logic [DEPTHLOG2:0]   LevelOut,
    output logic                 OverflowOut
);

    localparam int DEPTH = 2 ** DEPTHLOG2;
    localparam logic [DEPTHLOG2:0]   LEVEL_FULL = (DEPTHLOG2 + 1)'(DEPTH);
    localparam logic [DEPTHLOG2:0]   LEVEL_ONE  = (DEPTHLOG2 + 1)'(1);
    localparam logic [DEPTHLOG2-1:0] PTR_ONE    = DEPTHLOG2'(1);

    // state  | meaning
    // IDLE   | no write in progress; waiting for data and grant
    // SETUP  | address/data driven, strobe about to rise
    // STROBE | write strobe high
    // HOLD   | strobe low, address/data held; may chain the next entry
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t state_q, state_d;

    logic [AWIDTH+DWIDTH-1:0] mem_q [DEPTH];
    logic [DEPTHLOG2-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTHLOG2:0]       level_q, level_d;
    logic [AWIDTH-1:0]        addr_q, addr_d;
    logic [DWIDTH-1:0]        data_q, data_d;
    logic                     oe_q, oe_d, we_q, we_d, ovf_q, ovf_d;
    logic                     full, empty, push, drop, pop;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);
    // Full is the registered value, so a push while full is dropped even if a pop happens too.
    assign push  = WrStrobeIn && !full;
    assign drop  = WrStrobeIn && full;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        oe_d    = oe_q;
        we_d    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (!empty && BusGrantIn) begin
                    pop              = 1'b1;
                    {addr_d, data_d} = mem_q[rd_ptr_q];
                    oe_d             = 1'b1;
                    state_d          = SETUP;
                end else begin
                    oe_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            SETUP: begin
                we_d    = 1'b1;
                state_d = STROBE;
            end
            STROBE: begin
                we_d    = 1'b0;
                state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
        // A dropped push outranks a clear in the same cycle.
        ovf_d = drop ? 1'b1 : (OverflowClrIn ? 1'b0 : ovf_q);
    end

    always_ff @(posedge ClkIn) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {WrAddrIn, WrDataIn};
        end
    end

    always_ff @(posedge ClkIn) begin
        if (ResetIn) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            ovf_q    <= ovf_d;
        end
    end

    assign SramAddrOut   = addr_q;
    assign SramDataOut   = data_q;
    assign SramDataOeOut = oe_q;
    assign SramWeOut     = we_q;
    assign BusyOut       = (state_q != IDLE);
    assign EmptyOut      = empty;
    assign FullOut       = full;
    assign LevelOut      = level_q;
    assign OverflowOut   = ovf_q;

endmodule

// File: tb/tb_vram_write_queue.sv
// Directed bench for vram_write_queue: a vector table for single-entry timing
// plus hand sequences for fill/overflow, grant loss, push+pop and reset mid-cycle.
module tb_vram_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic [17:0] waddr;
    logic [7:0]  wdata;
    logic        gnt;
    logic        clr;
    logic [17:0] sram_addr;
    logic [7:0]  sram_data;
    logic        oe, we, busy, empty, full, ovf;
    logic [4:0]  level;

    int errors = 0;
    int checks = 0;

    vram_write_queue #(.AWIDTH(18), .DWIDTH(8), .DEPTHLOG2(4)) dut (
        .ClkIn(clk), .ResetIn(rst), .WrStrobeIn(stb), .WrAddrIn(waddr), .WrDataIn(wdata),
        .BusGrantIn(gnt), .OverflowClrIn(clr), .SramAddrOut(sram_addr), .SramDataOut(sram_data),
        .SramDataOeOut(oe), .SramWeOut(we), .BusyOut(busy), .EmptyOut(empty), .FullOut(full),
        .LevelOut(level), .OverflowOut(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stb;
        logic [17:0] addr;
        logic [7:0]  data;
        logic        gnt;
        logic [17:0] e_addr;
        logic [7:0]  e_data;
        logic        e_oe, e_we, e_busy, e_empty, e_full;
        logic [4:0]  e_lvl;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; stb = 1'b0; clr = 1'b0; gnt = 1'b0; waddr = '0; wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [17:0] a, input logic [7:0] d);
        stb = 1'b1; waddr = a; wdata = d;
        tick();
        stb = 1'b0;
    endtask

    // Grants continuously and checks n strobes carry addresses first..first+n-1 in order, 3 cycles apart.
    task automatic drain(input string nm, input logic [17:0] first, input int n, input logic [7:0] mask);
        int idx = 0;
        int last = 0;
        gnt = 1'b1;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (we) begin
                chk($sformatf("%s.addr%0d", nm, idx), 32'(sram_addr), 32'(first + 18'(idx)));
                chk($sformatf("%s.data%0d", nm, idx), 32'(sram_data), 32'(8'(first + 18'(idx)) ^ mask));
                if (idx > 0) chk($sformatf("%s.gap%0d", nm, idx), 32'(c - last), 32'd3);
                last = c;
                idx++;
            end
            if (idx >= n && !busy) break;
        end
        chk({nm, ".count"}, 32'(idx), 32'(n));
        chk({nm, ".empty"}, 32'(empty), 32'd1);
    endtask

    function automatic vec_t mk(input logic s, input logic [17:0] a, input logic [7:0] d, input logic g,
                                input logic [17:0] ea, input logic [7:0] ed, input logic eoe, input logic ewe,
                                input logic eb, input logic eem, input logic efu, input logic [4:0] el,
                                input logic eov);
        vec_t v;
        v.stb = s; v.addr = a; v.data = d; v.gnt = g;
        v.e_addr = ea; v.e_data = ed; v.e_oe = eoe; v.e_we = ewe; v.e_busy = eb;
        v.e_empty = eem; v.e_full = efu; v.e_lvl = el; v.e_ovf = eov;
        return v;
    endfunction

    initial begin
        int wcount;
        //             stb   addr        data   gnt   e_addr      e_data oe    we    busy  empty full  lvl   ovf
        vecs[0]  = mk(1'b0, 18'h0,     8'h00, 1'b1, 18'h0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        vecs[1]  = mk(1'b1, 18'h12345, 8'hA5, 1'b1, 18'h0,     8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0);
        vecs[2]  = mk(1'b0, 18'h0,     8'h00, 1'b1, 18'h12345, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        vecs[3]  = mk(1'b0, 18'h0,     8'h00, 1'b1, 18'h12345, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        vecs[4]  = mk(1'b0, 18'h0,     8'h00, 1'b0, 18'h12345, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        vecs[5]  = mk(1'b0, 18'h0,     8'h00, 1'b1, 18'h12345, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        vecs[6]  = mk(1'b1, 18'h1,     8'h11, 1'b1, 18'h12345, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0);
        vecs[7]  = mk(1'b1, 18'h2,     8'h22, 1'b1, 18'h1,     8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0);
        vecs[8]  = mk(1'b0, 18'h0,     8'h00, 1'b1, 18'h1,     8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0);
        vecs[9]  = mk(1'b0, 18'h0,     8'h00, 1'b1, 18'h1,     8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0);
        vecs[10] = mk(1'b0, 18'h0,     8'h00, 1'b1, 18'h2,     8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        vecs[11] = mk(1'b0, 18'h0,     8'h00, 1'b0, 18'h2,     8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        vecs[12] = mk(1'b0, 18'h0,     8'h00, 1'b0, 18'h2,     8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        vecs[13] = mk(1'b0, 18'h0,     8'h00, 1'b0, 18'h2,     8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);

        // Reset and idle: no strobe may appear.
        reset_dut();
        wcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (we) wcount++;
        end
        chk("idle.we_count", 32'(wcount), 32'd0);

        for (int i = 0; i < 14; i++) begin
            stb = vecs[i].stb; waddr = vecs[i].addr; wdata = vecs[i].data; gnt = vecs[i].gnt;
            tick();
            chk($sformatf("vec%0d.addr", i),  32'(sram_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d.data", i),  32'(sram_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d.oe", i),    32'(oe),        32'(vecs[i].e_oe));
            chk($sformatf("vec%0d.we", i),    32'(we),        32'(vecs[i].e_we));
            chk($sformatf("vec%0d.busy", i),  32'(busy),      32'(vecs[i].e_busy));
            chk($sformatf("vec%0d.empty", i), 32'(empty),     32'(vecs[i].e_empty));
            chk($sformatf("vec%0d.full", i),  32'(full),      32'(vecs[i].e_full));
            chk($sformatf("vec%0d.level", i), 32'(level),     32'(vecs[i].e_lvl));
            chk($sformatf("vec%0d.ovf", i),   32'(ovf),       32'(vecs[i].e_ovf));
        end
        stb = 1'b0;

        // Fill to full with no grant, overflow, clear-vs-drop priority, then drain in order.
        reset_dut();
        for (int i = 0; i < 16; i++) push(18'(i), 8'(i) ^ 8'hFF);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.level", 32'(level), 32'd16);
        chk("fill.ovf_before", 32'(ovf), 32'd0);
        clr = 1'b1;
        push(18'h3FFFF, 8'h00);
        clr = 1'b0;
        chk("fill.ovf_drop_with_clr", 32'(ovf), 32'd1);
        chk("fill.level_after_drop", 32'(level), 32'd16);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("fill.ovf_cleared", 32'(ovf), 32'd0);
        drain("fill", 18'h0, 16, 8'hFF);

        // Grant dropped in STROBE: cycle completes, next entry waits in IDLE.
        reset_dut();
        push(18'h100, 8'h00);
        push(18'h101, 8'h01);
        gnt = 1'b1;
        tick();
        chk("nogrant.setup_addr", 32'(sram_addr), 32'h100);
        gnt = 1'b0;
        tick();
        chk("nogrant.strobe_we", 32'(we), 32'd1);
        tick();
        chk("nogrant.hold_we", 32'(we), 32'd0);
        chk("nogrant.hold_busy", 32'(busy), 32'd1);
        chk("nogrant.hold_oe", 32'(oe), 32'd1);
        tick();
        chk("nogrant.idle_busy", 32'(busy), 32'd0);
        chk("nogrant.idle_oe", 32'(oe), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("nogrant.wait_busy", 32'(busy), 32'd0);
        chk("nogrant.wait_level", 32'(level), 32'd1);
        gnt = 1'b1;
        tick();
        chk("nogrant.resume_addr", 32'(sram_addr), 32'h101);
        chk("nogrant.resume_level", 32'(level), 32'd0);

        // Push+pop at level 3, then a push while full with a simultaneous pop.
        reset_dut();
        for (int i = 0; i < 3; i++) push(18'h10 + 18'(i), 8'h10 + 8'(i));
        gnt = 1'b1;
        push(18'h13, 8'h13);
        gnt = 1'b0;
        chk("pushpop.level", 32'(level), 32'd3);
        chk("pushpop.addr", 32'(sram_addr), 32'h10);
        for (int i = 0; i < 3; i++) tick();
        chk("pushpop.idle", 32'(busy), 32'd0);
        for (int i = 0; i < 13; i++) push(18'h14 + 18'(i), 8'h14 + 8'(i));
        chk("fullpop.full", 32'(full), 32'd1);
        gnt = 1'b1;
        push(18'h3ABCD, 8'hCD);
        chk("fullpop.level", 32'(level), 32'd15);
        chk("fullpop.ovf", 32'(ovf), 32'd1);
        chk("fullpop.addr", 32'(sram_addr), 32'h11);
        drain("fullpop", 18'h11, 16, 8'h00);

        // Reset while in SETUP with 5 entries queued.
        reset_dut();
        for (int i = 0; i < 6; i++) push(18'h40 + 18'(i), 8'h40 + 8'(i));
        gnt = 1'b1;
        tick();
        chk("rst.pre_level", 32'(level), 32'd5);
        chk("rst.pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst.we", 32'(we), 32'd0);
        chk("rst.level", 32'(level), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.oe", 32'(oe), 32'd0);
        chk("rst.addr", 32'(sram_addr), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        wcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (we || busy) wcount++;
        end
        chk("rst.no_writes", 32'(wcount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_write_queue.md
# vram_write_queue

Buffers byte writes from the video command receiver and commits them to the external video SRAM. It sits directly downstream of the command receiver and consumes its data strobe, write address and data byte. Each entry is written with a three-phase SRAM write cycle (setup, strobe, hold), and only in cycles where the memory arbiter grants the port. A small FIFO absorbs bursts that arrive while the display scan-out owns the SRAM.

## Interface
- AWIDTH, 18, SRAM address width
- DWIDTH, 8, SRAM data width
- DEPTHLOG2, 4, FIFO depth = 2**DEPTHLOG2 entries
- ClkIn  in  1  system clock; all logic on rising edge
- ResetIn  in  1  synchronous, active-high reset
- WrStrobeIn  in  1  one-cycle push request; already synchronised to ClkIn
- WrAddrIn  in  AWIDTH  write address, sampled with WrStrobeIn
- WrDataIn  in  DWIDTH  write data, sampled with WrStrobeIn
- BusGrantIn  in  1  SRAM port available to this block this cycle
- OverflowClrIn  in  1  clears OverflowOut
- SramAddrOut  out  AWIDTH  registered SRAM address
- SramDataOut  out  DWIDTH  registered SRAM write data
- SramDataOeOut  out  1  data bus drive enable
- SramWeOut  out  1  write strobe, active-high; the pad inverts it
- BusyOut  out  1  write cycle in progress (state != IDLE)
- EmptyOut  out  1  FIFO empty
- FullOut  out  1  FIFO full
- LevelOut  out  DEPTHLOG2+1  FIFO occupancy, 0..2**DEPTHLOG2
- OverflowOut  out  1  sticky; a push was dropped

## Operation
- FIFO: circular buffer with DEPTHLOG2-bit read/write pointers and a separate occupancy counter.
  - Pointers wrap modulo 2**DEPTHLOG2.
  - FullOut = (Level == 2**DEPTHLOG2); EmptyOut = (Level == 0). Both are derived from the registered Level.
- Push: WrStrobeIn high and FullOut low stores {WrAddrIn, WrDataIn} and increments the write pointer.
- Push while FullOut high: the entry is dropped and OverflowOut is set.
  - The drop applies even if a pop happens in the same cycle. Full status is the registered value, with no pop-through.
- Simultaneous push and pop with FIFO not full: Level is unchanged and both pointers advance.
- OverflowOut: set by a dropped push, cleared by OverflowClrIn. If both occur in the same cycle, set wins.
- Write FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: if !EmptyOut && BusGrantIn, pop the head entry, load SramAddrOut/SramDataOut, set SramDataOeOut=1, go to SETUP. Otherwise stay in IDLE.
  - SETUP: SramWeOut <= 1; go to STROBE.
  - STROBE: SramWeOut <= 0; go to HOLD.
  - HOLD: if !EmptyOut && BusGrantIn, pop and reload as in IDLE, keep SramDataOeOut=1, go to SETUP (back-to-back). Otherwise SramDataOeOut <= 0 and go to IDLE.
- BusGrantIn is sampled only in IDLE and HOLD. Once SETUP is entered the cycle runs to HOLD regardless of BusGrantIn; the arbiter guarantees a 3-cycle window after a grant is used.
- Address and data are held constant from SETUP through HOLD. SramAddrOut keeps its last value in IDLE.
- No merging or reordering: entries are written strictly in push order.
- ResetIn (at any time, including mid-cycle): at the next edge,
  - pointers and Level go to 0;
  - all FIFO contents are discarded;
  - FSM goes to IDLE;
  - all outputs take their reset values.

## Timing
- Reset values: SramAddrOut=0, SramDataOut=0, SramDataOeOut=0, SramWeOut=0, BusyOut=0, EmptyOut=1, FullOut=0, LevelOut=0, OverflowOut=0.
- Push at edge N: LevelOut/EmptyOut update at N. The earliest pop is at edge N+1, given grant in cycle N+1.
- Pop at edge k:
  - SramAddrOut/SramDataOut/SramDataOeOut valid from k;
  - SramWeOut high for exactly one cycle, edge k+1 to k+2;
  - address/data stable one cycle before and one cycle after the strobe.
- Throughput: back-to-back 1 entry per 3 cycles. With an IDLE gap, 1 per 4 cycles.
- Latency with an empty FIFO and continuous grant: strobe to SramWeOut rising = 2 edges.
- All outputs are registered; there is no combinational path from inputs to SRAM pins.

## Test plan
- Reset, then idle → all outputs at reset values; EmptyOut=1; SramWeOut never high.
- Push addr 0x12345/data 0xA5 with BusGrantIn=1 → SramAddrOut=0x12345 and SramDataOut=0xA5 one edge later; SramWeOut high exactly one cycle, two edges after the push; BusyOut low after HOLD.
- BusGrantIn=0, push 16 entries (addr 0..15, data = addr^0xFF) → FullOut=1 and LevelOut=16; a 17th push sets OverflowOut and is dropped. Then grant=1 → 16 writes in order, 3 cycles apart, and EmptyOut=1 at the end.
- Grant deasserted in STROBE → the cycle completes through HOLD; the next entry waits in IDLE until grant returns.
- Push and pop in the same cycle at Level=3 → Level stays 3. Push while full with a simultaneous pop → still dropped and OverflowOut=1. OverflowClrIn together with a dropped push → OverflowOut stays 1.
- ResetIn asserted in SETUP with 5 entries queued → next edge: SramWeOut=0, LevelOut=0, state IDLE; no further SRAM writes.
